// File: rtl/iic_pkg.sv
// iic_pkg: shared constants for the I2C target controller.
//   - register offsets (decoded on address bits [7:0])
//   - FSM state encoding (4 bits)
//   - STATUS register bit positions
package iic_pkg;

    localparam int unsigned MAX_BIT_POS = 31;
    localparam int unsigned DW          = MAX_BIT_POS + 1;

    localparam logic [7:0] OFS_CONFIG  = 8'h00;
    localparam logic [7:0] OFS_STATUS  = 8'h04;
    localparam logic [7:0] OFS_RX_DATA = 8'h08;
    localparam logic [7:0] OFS_TX_DATA = 8'h0C;

    localparam int unsigned STAT_WR_DONE = 0;
    localparam int unsigned STAT_RD_DONE = 1;
    localparam int unsigned STAT_BUSY    = 2;
    localparam int unsigned STAT_PTR_LO  = 3;
    localparam int unsigned STAT_PTR_HI  = 4;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StAddr     = 4'd1,
        StAddrAck  = 4'd2,
        StReg      = 4'd3,
        StRegAck   = 4'd4,
        StWdata    = 4'd5,
        StWdataAck = 4'd6,
        StRdata    = 4'd7,
        StRdataAck = 4'd8,
        StIgnore   = 4'd9
    } iic_state_e;

endpackage

// File: rtl/iic_slave_bus_sync.sv
// iic_bus_sync: brings SCL/SDA into the clk domain and detects bus events.
//   clk, rst_n  : system clock, synchronous active-low reset
//   i_scl/i_sda : raw bus pins
//   scl_rise/scl_fall/start_det/stop_det : one-cycle pulses, 3 clk after the pin change
//   sda_s       : synchronized SDA, aligned with the event pulses
module iic_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic r_scl_meta, r_scl_sync, r_scl_prev;
    logic r_sda_meta, r_sda_sync, r_sda_prev;
    logic r_scl_rise, r_scl_fall, r_sda_s, r_start, r_stop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Reset to the idle-bus level so leaving reset never looks like a START.
            r_scl_meta <= 1'b1;
            r_scl_sync <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_sync <= 1'b1;
            r_sda_prev <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_sda_s    <= 1'b1;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_meta <= i_scl;
            r_scl_sync <= r_scl_meta;
            r_scl_prev <= r_scl_sync;
            r_sda_meta <= i_sda;
            r_sda_sync <= r_sda_meta;
            r_sda_prev <= r_sda_sync;
            r_scl_rise <= r_scl_sync & ~r_scl_prev;
            r_scl_fall <= ~r_scl_sync & r_scl_prev;
            r_sda_s    <= r_sda_sync;
            r_start    <= r_scl_sync & r_scl_prev & ~r_sda_sync & r_sda_prev;
            r_stop     <= r_scl_sync & r_scl_prev & r_sda_sync & ~r_sda_prev;
        end
    end

    assign scl_rise  = r_scl_rise;
    assign scl_fall  = r_scl_fall;
    assign sda_s     = r_sda_s;
    assign start_det = r_start;
    assign stop_det  = r_stop;

endmodule

// File: rtl/iic_slave.sv
// iic_slave: I2C target with a 4-byte RX buffer, 4-byte TX buffer and CPU register port.
//   clk, rst_n          : system clock, synchronous active-low reset
//   iic_scl, iic_sda    : bus pins (SDA is open drain: driven 0 or Z only)
//   iic_reg_*           : register port (CONFIG/STATUS/RX_DATA/TX_DATA), 1-cycle response
//   iic_ready           : access acknowledge, 1 clk after the strobe
//   data_ready_int      : wr_done & enable
//   write_ready_int     : rd_done & enable
module iic_slave
    import iic_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iic_scl,
    inout  wire           iic_sda,
    input  logic          iic_reg_wr_en,
    input  logic          iic_reg_rd_en,
    input  logic [DW-1:0] iic_reg_addr,
    input  logic [DW-1:0] iic_reg_wdata,
    output logic [DW-1:0] iic_reg_rdata,
    output logic          iic_ready,
    output logic          data_ready_int,
    output logic          write_ready_int
);

    logic w_scl_rise, w_scl_fall, w_sda_s, w_start, w_stop;

    iic_bus_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_scl     (iic_scl),
        .i_sda     (iic_sda),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .sda_s     (w_sda_s),
        .start_det (w_start),
        .stop_det  (w_stop)
    );

    iic_state_e      r_state;
    logic [7:0]      r_cfg;
    logic [3:0][7:0] r_rx, r_tx;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic [1:0]      r_ptr;
    logic            r_sda_low, r_busy, r_wr_any, r_rd_xfer, r_ack_pend;
    logic            r_wr_done, r_rd_done, r_ready;
    logic [DW-1:0]   r_rdata;

    logic            w_en;
    logic [7:0]      w_byte, w_ofs;
    logic            w_last_bit, w_set_wr, w_set_rd, w_clr_wr, w_clr_rd;
    logic [DW-1:0]   w_rd_mux;
    logic            w_unused;

    assign w_en       = r_cfg[7];
    assign w_byte     = {r_shift[6:0], w_sda_s};
    assign w_last_bit = (r_bit_cnt == 3'd7);
    assign w_ofs      = iic_reg_addr[7:0];
    assign w_unused   = ^{iic_reg_addr[DW-1:8], r_shift[7]};

    assign w_set_wr = w_en & w_stop & r_wr_any;
    assign w_set_rd = w_en & ((w_stop & r_rd_xfer) |
                      ((r_state == StRdataAck) & w_scl_rise & w_sda_s));
    assign w_clr_wr = iic_reg_wr_en & (w_ofs == OFS_STATUS) & iic_reg_wdata[STAT_WR_DONE];
    assign w_clr_rd = iic_reg_wr_en & (w_ofs == OFS_STATUS) & iic_reg_wdata[STAT_RD_DONE];

    // Bus-side FSM. Bits are sampled on SCL rise; SDA drive only changes on SCL fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_rx       <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_ptr      <= '0;
            r_sda_low  <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_any   <= 1'b0;
            r_rd_xfer  <= 1'b0;
            r_ack_pend <= 1'b0;
        end else if (!w_en) begin
            r_state    <= StIdle;
            r_sda_low  <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_any   <= 1'b0;
            r_rd_xfer  <= 1'b0;
            r_ack_pend <= 1'b0;
        end else if (w_start) begin
            r_state    <= StAddr;
            r_bit_cnt  <= '0;
            r_sda_low  <= 1'b0;
            r_busy     <= 1'b1;
            r_wr_any   <= 1'b0;
            r_rd_xfer  <= 1'b0;
            r_ack_pend <= 1'b0;
        end else if (w_stop) begin
            r_state    <= StIdle;
            r_sda_low  <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_any   <= 1'b0;
            r_rd_xfer  <= 1'b0;
            r_ack_pend <= 1'b0;
        end else begin
            case (r_state)
                StAddr, StReg, StWdata: begin
                    if (w_scl_rise) begin
                        r_shift   <= w_byte;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_last_bit) begin
                            if (r_state == StAddr) begin
                                if (w_byte[7:1] == r_cfg[6:0]) begin
                                    r_state   <= StAddrAck;
                                    r_rd_xfer <= w_byte[0];
                                end else begin
                                    r_state <= StIgnore;
                                end
                            end else if (r_state == StReg) begin
                                r_ptr   <= w_byte[1:0];
                                r_state <= StRegAck;
                            end else begin
                                r_rx[r_ptr] <= w_byte;
                                r_ptr       <= r_ptr + 2'd1;
                                r_wr_any    <= 1'b1;
                                r_state     <= StWdataAck;
                            end
                        end
                    end
                end
                // ACK is held from the 8th SCL fall to the 9th; the 9th fall also
                // loads the first read byte when the master asked for a read.
                StAddrAck, StRegAck, StWdataAck: begin
                    if (w_scl_fall) begin
                        if (!r_sda_low) begin
                            r_sda_low <= 1'b1;
                        end else if (r_state == StAddrAck && r_rd_xfer) begin
                            r_state   <= StRdata;
                            r_shift   <= r_tx[r_ptr];
                            r_sda_low <= ~r_tx[r_ptr][7];
                        end else begin
                            r_state   <= (r_state == StAddrAck) ? StReg : StWdata;
                            r_sda_low <= 1'b0;
                        end
                    end
                end
                StRdata: begin
                    if (w_scl_rise) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end else if (w_scl_fall) begin
                        // Counter wraps to 0 after the 8th rise: byte is done.
                        if (r_bit_cnt == 3'd0) begin
                            r_sda_low <= 1'b0;
                            r_ptr     <= r_ptr + 2'd1;
                            r_state   <= StRdataAck;
                        end else begin
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_sda_low <= ~r_shift[6];
                        end
                    end
                end
                StRdataAck: begin
                    if (w_scl_rise) begin
                        if (!w_sda_s) begin
                            r_ack_pend <= 1'b1;
                        end else begin
                            r_state   <= StIgnore;
                            r_rd_xfer <= 1'b0;
                        end
                    end else if (w_scl_fall && r_ack_pend) begin
                        r_ack_pend <= 1'b0;
                        r_state    <= StRdata;
                        r_shift    <= r_tx[r_ptr];
                        r_sda_low  <= ~r_tx[r_ptr][7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_ofs)
            OFS_CONFIG:  w_rd_mux[7:0] = r_cfg;
            OFS_STATUS: begin
                w_rd_mux[STAT_WR_DONE]              = r_wr_done;
                w_rd_mux[STAT_RD_DONE]              = r_rd_done;
                w_rd_mux[STAT_BUSY]                 = r_busy;
                w_rd_mux[STAT_PTR_HI:STAT_PTR_LO]   = r_ptr;
            end
            OFS_RX_DATA: w_rd_mux = r_rx;
            OFS_TX_DATA: w_rd_mux = r_tx;
            default:     ;
        endcase
    end

    // CPU register port. A hardware set wins over a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cfg     <= '0;
            r_tx      <= '0;
            r_wr_done <= 1'b0;
            r_rd_done <= 1'b0;
            r_ready   <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_ready   <= iic_reg_wr_en | iic_reg_rd_en;
            r_wr_done <= w_set_wr | (r_wr_done & ~w_clr_wr);
            r_rd_done <= w_set_rd | (r_rd_done & ~w_clr_rd);
            if (iic_reg_wr_en) begin
                if (w_ofs == OFS_CONFIG) begin
                    r_cfg <= iic_reg_wdata[7:0];
                end else if (w_ofs == OFS_TX_DATA) begin
                    r_tx <= iic_reg_wdata;
                end
            end else if (iic_reg_rd_en) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign iic_sda         = r_sda_low ? 1'b0 : 1'bz;
    assign iic_reg_rdata   = r_rdata;
    assign iic_ready       = r_ready;
    assign data_ready_int  = r_wr_done & w_en;
    assign write_ready_int = r_rd_done & w_en;

endmodule

// File: tb/tb_iic_slave.sv
// tb_iic_slave: bit-banged I2C master plus CPU register driver around iic_slave, checked
// against a transaction-level model (RX/TX byte arrays, pointer and done flags).
module tb_iic_slave;

    localparam logic [31:0] A_CONFIG = 32'h00;
    localparam logic [31:0] A_STATUS = 32'h04;
    localparam logic [31:0] A_RX     = 32'h08;
    localparam logic [31:0] A_TX     = 32'h0C;
    localparam int Q = 10;  // clk cycles: data setup / quarter of an SCL period
    localparam int H = 20;  // clk cycles: SCL high time

    logic        clk = 1'b0;
    logic        rst_n, scl, m_low, wr_en, rd_en;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, dri, wri;
    wire         sda_bus;

    pullup (sda_bus);
    assign sda_bus = m_low ? 1'b0 : 1'bz;

    iic_slave u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .iic_scl         (scl),
        .iic_sda         (sda_bus),
        .iic_reg_wr_en   (wr_en),
        .iic_reg_rd_en   (rd_en),
        .iic_reg_addr    (addr),
        .iic_reg_wdata   (wdata),
        .iic_reg_rdata   (rdata),
        .iic_ready       (ready),
        .data_ready_int  (dri),
        .write_ready_int (wri)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]      m_cfg;
    logic [3:0][7:0] m_rx, m_tx;
    logic [1:0]      m_ptr;
    logic            m_wr, m_rd;
    logic [7:0]      wbuf [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        cyc(1);
        wr_en = 1'b0;
        check_bit("wr_ready", ready, 1'b1);
    endtask

    task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd_en = 1'b1;
        cyc(1);
        rd_en = 1'b0;
        d = rdata;
    endtask

    task automatic set_cfg(input logic [7:0] v);
        reg_write(A_CONFIG, {24'd0, v});
        m_cfg = v;
    endtask

    task automatic clear_flags();
        reg_write(A_STATUS, 32'h3);
        m_wr = 1'b0;
        m_rd = 1'b0;
    endtask

    // One SCL clock: present b (1 = release), pulse SCL, sample SDA mid-high.
    task automatic bus_bit(input logic b, output logic s);
        m_low = ~b;
        cyc(Q);
        scl = 1'b1;
        cyc(H / 2);
        s = sda_bus;
        cyc(H / 2);
        scl = 1'b0;
        cyc(Q);
    endtask

    task automatic bus_start();
        m_low = 1'b0;
        cyc(Q);
        scl = 1'b1;
        cyc(Q);
        m_low = 1'b1;
        cyc(Q);
        scl = 1'b0;
        cyc(Q);
    endtask

    // collide=1 lines a STATUS W1C of wr_done up with the edge where STOP sets it.
    task automatic bus_stop(input bit collide);
        m_low = 1'b1;
        cyc(Q);
        scl = 1'b1;
        cyc(Q);
        m_low = 1'b0;
        if (collide) begin
            cyc(3);
            addr = A_STATUS; wdata = 32'h1; wr_en = 1'b1;
            cyc(1);
            wr_en = 1'b0;
            cyc(Q);
        end else begin
            cyc(Q);
        end
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(output logic [7:0] d, input bit give_ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(~give_ack, s);
    endtask

    task automatic xfer_write(input logic [6:0] a, input logic [7:0] rp, input int n,
                              input bit collide, input string tag);
        logic        ack, hit, any;
        logic [31:0] st;
        hit = m_cfg[7] && (a == m_cfg[6:0]);
        any = 1'b0;
        bus_start();
        reg_read(A_STATUS, st);
        check_bit({tag, "_busy"}, st[2], m_cfg[7]);
        write_byte({a, 1'b0}, ack);
        check_bit({tag, "_addr_ack"}, ack, hit);
        if (hit) begin
            write_byte(rp, ack);
            check_bit({tag, "_reg_ack"}, ack, 1'b1);
            m_ptr = rp[1:0];
            for (int i = 0; i < n; i++) begin
                write_byte(wbuf[i], ack);
                check_bit({tag, "_data_ack"}, ack, 1'b1);
                m_rx[m_ptr] = wbuf[i];
                m_ptr = m_ptr + 2'd1;
                any = 1'b1;
            end
        end
        bus_stop(collide);
        if (any) m_wr = 1'b1;
    endtask

    // Register-pointer write, repeated START, then n reads (last one NACKed).
    task automatic xfer_read(input logic [7:0] rp, input int n, input string tag);
        logic       ack;
        logic [7:0] d;
        bus_start();
        write_byte({m_cfg[6:0], 1'b0}, ack);
        check_bit({tag, "_waddr_ack"}, ack, 1'b1);
        write_byte(rp, ack);
        check_bit({tag, "_reg_ack"}, ack, 1'b1);
        m_ptr = rp[1:0];
        bus_start();
        write_byte({m_cfg[6:0], 1'b1}, ack);
        check_bit({tag, "_raddr_ack"}, ack, 1'b1);
        for (int i = 0; i < n; i++) begin
            read_byte(d, i < n - 1);
            check({tag, "_rbyte"}, {24'd0, d}, {24'd0, m_tx[m_ptr]});
            m_ptr = m_ptr + 2'd1;
        end
        m_rd = 1'b1;
        bus_stop(1'b0);
    endtask

    task automatic check_state(input string tag);
        logic [31:0] d;
        reg_read(A_RX, d);
        check({tag, "_rx"}, d, m_rx);
        reg_read(A_STATUS, d);
        check({tag, "_status"}, d, {27'd0, m_ptr, 1'b0, m_rd, m_wr});
        check_bit({tag, "_data_int"}, dri, m_wr & m_cfg[7]);
        check_bit({tag, "_write_int"}, wri, m_rd & m_cfg[7]);
    endtask

    initial begin
        logic [31:0] d;
        logic        s;
        rst_n = 1'b0; scl = 1'b1; m_low = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;
        m_cfg = '0; m_rx = '0; m_tx = '0; m_ptr = '0; m_wr = 1'b0; m_rd = 1'b0;
        cyc(5);
        check_bit("rst_sda", sda_bus, 1'b1);
        check("rst_rdata", rdata, 32'd0);
        check_bit("rst_ready", ready, 1'b0);
        check_bit("rst_dint", dri, 1'b0);
        check_bit("rst_wint", wri, 1'b0);
        rst_n = 1'b1;
        cyc(2);
        reg_read(A_CONFIG, d);
        check("rst_config", d, 32'd0);
        check_state("rst");

        // 1: addressed write, pointer 1, two data bytes
        set_cfg(8'hD0);
        wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
        xfer_write(7'h50, 8'h01, 2, 1'b0, "t1");
        check_state("t1");
        check("t1_rx_const", m_rx, 32'h00BBAA00);

        // Disabled: no ACK, flags retained but interrupts masked
        set_cfg(8'h50);
        wbuf[0] = 8'h77;
        xfer_write(7'h50, 8'h00, 1, 1'b0, "dis");
        check_state("dis");
        set_cfg(8'hD0);
        clear_flags();

        // 2: address mismatch
        wbuf[0] = 8'hCC;
        xfer_write(7'h51, 8'h00, 1, 1'b0, "t2");
        check_state("t2");

        // 3: read with repeated START and pointer wrap
        reg_write(A_TX, 32'h44332211);
        m_tx = 32'h44332211;
        reg_read(A_TX, d);
        check("t3_tx_rb", d, 32'h44332211);
        xfer_read(8'h03, 2, "t3");
        check_state("t3");
        clear_flags();

        // 4: write overflow wraps and overwrites
        for (int i = 0; i < 5; i++) wbuf[i] = 8'(i + 1);
        xfer_write(7'h50, 8'h00, 5, 1'b0, "t4");
        check("t4_rx_const", m_rx, 32'h04030205);
        check_state("t4");
        clear_flags();

        // 5: W1C colliding with the STOP that sets wr_done
        wbuf[0] = 8'h5A;
        xfer_write(7'h50, 8'h02, 1, 1'b1, "t5");
        check_state("t5");
        addr = A_STATUS; wdata = 32'h1; wr_en = 1'b1;
        cyc(1);
        wr_en = 1'b0;
        check_bit("t5_int_drop", dri, 1'b0);
        m_wr = 1'b0;
        check_state("t5_clr");

        // 6: reset while the target holds the address ACK low
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(((8'hA0 >> i) & 8'h1) != 0, s);
        m_low = 1'b0;
        cyc(1);
        check_bit("t6_ack_low", sda_bus, 1'b0);
        rst_n = 1'b0;
        cyc(1);
        check_bit("t6_sda_rel", sda_bus, 1'b1);
        check("t6_rdata", rdata, 32'd0);
        check_bit("t6_ready", ready, 1'b0);
        check_bit("t6_dint", dri, 1'b0);
        check_bit("t6_wint", wri, 1'b0);
        rst_n = 1'b1;
        m_cfg = '0; m_rx = '0; m_tx = '0; m_ptr = '0; m_wr = 1'b0; m_rd = 1'b0;
        cyc(1);
        bus_stop(1'b0);
        check_state("t6_rst");
        set_cfg(8'hD0);
        wbuf[0] = 8'h12; wbuf[1] = 8'h34;
        xfer_write(7'h50, 8'h03, 2, 1'b0, "t6");
        check_state("t6");
        clear_flags();

        // Randomized write/read rounds
        for (int it = 0; it < 4; it++) begin
            int n;
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < 8; i++) wbuf[i] = 8'($urandom_range(0, 255));
            xfer_write(7'h50, 8'($urandom_range(0, 255)), n, 1'b0, "rw");
            check_state("rw");
            d = $urandom;
            reg_write(A_TX, d);
            m_tx = d;
            xfer_read(8'($urandom_range(0, 255)), int'($urandom_range(1, 5)), "rr");
            check_state("rr");
            clear_flags();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
